// File: rtl/psum_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : psum_buffer_ctrl
// Brief    : Partial-sum scratchpad and responder for the controller psum
//            handshake: fill, read, read-modify-write accumulate, stall codes.
//            Optional build macro PSUM_SATURATE_EN selects saturating adds.
// Revision : 1.0 - initial release
// ============================================================================
module psum_buffer_ctrl #(
  parameter int PSUM_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  global_rst,
  input  logic [ADDR_W:0]       num_psums,
  input  logic [PSUM_WIDTH-1:0] result_in,
  input  logic                  next_psum_waddr,
  input  logic                  psum_buffer_ren,
  input  logic                  done,
  input  logic                  next_psum_raddr,
  output logic                  can_read_psum,
  output logic                  psum_buffer_valid,
  output logic [PSUM_WIDTH-1:0] psum_rdata,
  output logic                  psum_w_co,
  output logic [1:0]            stall,
  output logic                  error
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_WAIT = 3'd1;
  localparam logic [2:0] S_VALID   = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  localparam logic [1:0] C_STALL_BUSY = 2'b00;
  localparam logic [1:0] C_STALL_NEXT = 2'b10;
  localparam logic [1:0] C_STALL_FIN  = 2'b11;

  localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [2:0]            r_state;
  logic [2:0]            w_state_nxt;
  logic [ADDR_W-1:0]     r_waddr;
  logic [ADDR_W-1:0]     r_raddr;
  logic [PSUM_WIDTH-1:0] r_rd_q;
  logic [PSUM_WIDTH-1:0] r_add_op;
  logic                  r_finished;
  logic                  r_error;
  logic [PSUM_WIDTH-1:0] r_rdata;
  logic [PSUM_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_W:0]       w_num_eff;
  logic [ADDR_W-1:0]     w_last;
  logic                  w_raddr_last;
  logic [ADDR_W-1:0]     w_waddr_inc;
  logic [ADDR_W-1:0]     w_raddr_inc;
  logic                  w_rd_issue;
  logic                  w_fill_wr;
  logic                  w_acc_wr;
  logic                  w_err_evt;
  logic [PSUM_WIDTH-1:0] w_sum;

  // Zero or oversize entry counts fall back to the full buffer.
  assign w_num_eff    = (num_psums == '0 || num_psums > C_DEPTH) ? C_DEPTH : num_psums;
  assign w_last       = ADDR_W'(w_num_eff - 1'b1);
  assign w_raddr_last = (r_raddr == w_last);
  assign w_waddr_inc  = (r_waddr == w_last) ? '0 : r_waddr + 1'b1;
  assign w_raddr_inc  = w_raddr_last ? '0 : r_raddr + 1'b1;

  assign w_rd_issue = (r_state == S_IDLE) && psum_buffer_ren && !r_finished;
  assign w_fill_wr  = (r_state == S_IDLE) && next_psum_waddr;
  assign w_acc_wr   = (r_state == S_WRITE);

  assign w_err_evt = (done && r_state != S_VALID)
                   || (next_psum_raddr && !(r_state == S_REPORT && !w_raddr_last))
                   || (next_psum_waddr && r_state != S_IDLE)
                   || (psum_buffer_ren && r_state != S_IDLE && r_state != S_DONE);

`ifdef PSUM_SATURATE_EN
  localparam logic [PSUM_WIDTH-1:0] C_SAT_MAX = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic [PSUM_WIDTH-1:0] C_SAT_MIN = {1'b1, {(PSUM_WIDTH-1){1'b0}}};
  logic [PSUM_WIDTH:0] w_sum_ext;
  assign w_sum_ext = {r_rdata[PSUM_WIDTH-1], r_rdata} + {r_add_op[PSUM_WIDTH-1], r_add_op};
  // Sign-extended sum disagreeing in its top two bits means overflow.
  assign w_sum = (w_sum_ext[PSUM_WIDTH] != w_sum_ext[PSUM_WIDTH-1])
               ? (w_sum_ext[PSUM_WIDTH] ? C_SAT_MIN : C_SAT_MAX)
               : w_sum_ext[PSUM_WIDTH-1:0];
`else
  assign w_sum = r_rdata + r_add_op;
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else if (global_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (w_rd_issue) w_state_nxt = S_RD_WAIT;
      S_RD_WAIT: w_state_nxt = S_VALID;
      S_VALID:   if (done) w_state_nxt = S_WRITE;
      S_WRITE:   w_state_nxt = S_REPORT;
      S_REPORT: begin
        if (w_raddr_last)         w_state_nxt = S_DONE;
        else if (next_psum_raddr) w_state_nxt = S_IDLE;
      end
      S_DONE:    w_state_nxt = S_DONE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    can_read_psum     = 1'b0;
    psum_buffer_valid = 1'b0;
    stall             = C_STALL_BUSY;
    case (r_state)
      S_IDLE:   can_read_psum     = !r_finished;
      S_VALID:  psum_buffer_valid = 1'b1;
      S_REPORT: stall             = w_raddr_last ? C_STALL_FIN : C_STALL_NEXT;
      S_DONE:   stall             = C_STALL_FIN;
      default:  stall             = C_STALL_BUSY;
    endcase
  end

  // Pointers, read pipeline and status flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_rd_q     <= '0;
      r_add_op   <= '0;
      r_rdata    <= '0;
      r_finished <= 1'b0;
      r_error    <= 1'b0;
    end else if (global_rst) begin
      r_waddr    <= '0;
      r_raddr    <= '0;
      r_rd_q     <= '0;
      r_add_op   <= '0;
      r_rdata    <= '0;
      r_finished <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      if (w_err_evt) r_error <= 1'b1;
      if (w_fill_wr) r_waddr <= w_waddr_inc;
      // Captured at issue so a same-cycle fill write to raddr is not seen.
      if (w_rd_issue) r_rd_q <= r_mem[r_raddr];
      if (r_state == S_RD_WAIT) r_rdata <= r_rd_q;
      if (r_state == S_VALID && done) r_add_op <= result_in;
      if (r_state == S_REPORT) begin
        if (w_raddr_last) begin
          r_finished <= 1'b1;
          r_raddr    <= '0;
        end else if (next_psum_raddr) begin
          r_raddr <= w_raddr_inc;
        end
      end
    end
  end

  // Scratchpad storage is deliberately left uninitialised across resets.
  always_ff @(posedge clk) begin
    if (!reset && !global_rst) begin
      if (w_fill_wr) begin
        r_mem[r_waddr] <= result_in;
      end else if (w_acc_wr) begin
        r_mem[r_raddr] <= w_sum;
      end
    end
  end

  assign psum_rdata = r_rdata;
  assign psum_w_co  = (r_waddr == w_last);
  assign error      = r_error;

endmodule
`default_nettype wire

// File: tb/tb_psum_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_psum_buffer_ctrl
// Brief    : Directed plus randomized bench for psum_buffer_ctrl with an
//            in-bench transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psum_buffer_ctrl;
  localparam int W  = 16;
  localparam int D  = 16;
  localparam int AW = 4;
`ifdef PSUM_SATURATE_EN
  localparam logic [W-1:0] EXP_OVF = 16'h7FFF;
`else
  localparam logic [W-1:0] EXP_OVF = 16'h8010;
`endif

  localparam int S_IDLE = 0, S_RDW = 1, S_VAL = 2, S_WR = 3, S_REP = 4, S_DONE = 5;

  logic          clk = 1'b0;
  logic          reset, global_rst;
  logic [AW:0]   num_psums;
  logic [W-1:0]  result_in;
  logic          next_psum_waddr, psum_buffer_ren, done, next_psum_raddr;
  logic          can_read_psum, psum_buffer_valid, psum_w_co, error;
  logic [W-1:0]  psum_rdata;
  logic [1:0]    stall;

  psum_buffer_ctrl #(.PSUM_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .reset(reset), .global_rst(global_rst), .num_psums(num_psums),
    .result_in(result_in), .next_psum_waddr(next_psum_waddr),
    .psum_buffer_ren(psum_buffer_ren), .done(done), .next_psum_raddr(next_psum_raddr),
    .can_read_psum(can_read_psum), .psum_buffer_valid(psum_buffer_valid),
    .psum_rdata(psum_rdata), .psum_w_co(psum_w_co), .stall(stall), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer contents plus the handshake phase and pointers.
  logic [W-1:0] m_mem [D];
  bit           m_known [D];
  int           m_st, m_wa, m_ra;
  logic [W-1:0] m_rdata, m_lat, m_addv;
  bit           m_rk, m_latk, m_err, m_fin;

  function automatic int m_last();
    int eff;
    eff = (num_psums == 0 || num_psums > D) ? D : int'(num_psums);
    return eff - 1;
  endfunction

  function automatic logic [W-1:0] m_accum(logic [W-1:0] a, logic [W-1:0] b);
    int s;
    s = $signed(a) + $signed(b);
`ifdef PSUM_SATURATE_EN
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
`endif
    return s[W-1:0];
  endfunction

  always @(posedge clk or posedge reset) begin : b_model
    int last;
    if (reset || global_rst) begin
      m_st = S_IDLE; m_wa = 0; m_ra = 0; m_rdata = '0; m_rk = 1'b1;
      m_err = 1'b0; m_fin = 1'b0; m_lat = '0; m_latk = 1'b1; m_addv = '0;
    end else begin
      last = m_last();
      if (done && m_st != S_VAL) m_err = 1'b1;
      if (next_psum_raddr && !(m_st == S_REP && m_ra != last)) m_err = 1'b1;
      if (next_psum_waddr && m_st != S_IDLE) m_err = 1'b1;
      if (psum_buffer_ren && !(m_st == S_IDLE || m_st == S_DONE)) m_err = 1'b1;
      case (m_st)
        S_IDLE: begin
          if (psum_buffer_ren && !m_fin) begin
            m_lat = m_mem[m_ra]; m_latk = m_known[m_ra]; m_st = S_RDW;
          end
          if (next_psum_waddr) begin
            m_mem[m_wa] = result_in; m_known[m_wa] = 1'b1;
            m_wa = (m_wa == last) ? 0 : (m_wa + 1) % D;
          end
        end
        S_RDW: begin m_rdata = m_lat; m_rk = m_latk; m_st = S_VAL; end
        S_VAL: if (done) begin m_addv = result_in; m_st = S_WR; end
        S_WR: begin
          m_mem[m_ra] = m_accum(m_rdata, m_addv);
          m_known[m_ra] = m_rk;
          m_st = S_REP;
        end
        S_REP: begin
          if (m_ra == last) begin
            m_fin = 1'b1; m_ra = 0; m_st = S_DONE;
          end else if (next_psum_raddr) begin
            m_ra = (m_ra + 1) % D; m_st = S_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin : b_compare
    logic [1:0] exp_stall;
    if (!reset) begin
      exp_stall = (m_st == S_REP) ? ((m_ra == m_last()) ? 2'b11 : 2'b10)
                : (m_st == S_DONE) ? 2'b11 : 2'b00;
      check("can_read_psum", can_read_psum, (m_st == S_IDLE) && !m_fin);
      check("psum_buffer_valid", psum_buffer_valid, m_st == S_VAL);
      check("stall", stall, exp_stall);
      check("psum_w_co", psum_w_co, m_wa == m_last());
      check("error", error, m_err);
      if (m_rk) check("psum_rdata", psum_rdata, m_rdata);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_grst();
    global_rst = 1'b1; tick(); global_rst = 1'b0;
  endtask

  task automatic do_entry(logic [W-1:0] addv, logic [W-1:0] exp_rd, logic [1:0] exp_code);
    psum_buffer_ren = 1'b1; tick(); psum_buffer_ren = 1'b0;
    check("rd_wait_no_valid", psum_buffer_valid, 1'b0);
    tick();
    check("valid_rise", psum_buffer_valid, 1'b1);
    check("entry_rdata", psum_rdata, exp_rd);
    tick();
    check("valid_hold", psum_buffer_valid, 1'b1);
    result_in = addv; done = 1'b1; tick(); done = 1'b0;
    check("write_stall", stall, 2'b00);
    tick();
    check("report_code", stall, exp_code);
    if (exp_code == 2'b10) begin
      tick();
      check("code_hold", stall, 2'b10);
      next_psum_raddr = 1'b1; tick(); next_psum_raddr = 1'b0;
      check("can_read_after_ack", can_read_psum, 1'b1);
    end else begin
      tick();
      check("finished_stall", stall, 2'b11);
      check("finished_no_read", can_read_psum, 1'b0);
    end
  endtask

  initial begin
    for (int i = 0; i < D; i++) begin m_known[i] = 1'b0; m_mem[i] = '0; end
    reset = 1'b1; global_rst = 1'b0; num_psums = 5'd3; result_in = '0;
    next_psum_waddr = 1'b0; psum_buffer_ren = 1'b0; done = 1'b0; next_psum_raddr = 1'b0;
    tick(3);
    reset = 1'b0;
    check("rst_stall", stall, 2'b00);
    check("rst_valid", psum_buffer_valid, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_rdata", psum_rdata, 16'h0);
    check("rst_can_read", can_read_psum, 1'b1);

    for (int i = 0; i < 3; i++) begin
      result_in = W'(5 + i); next_psum_waddr = 1'b1;
      check("w_co_fill", psum_w_co, i == 2);
      tick();
    end
    next_psum_waddr = 1'b0;
    check("w_co_wrapped", psum_w_co, 1'b0);

    do_entry(16'd10, 16'd5, 2'b10);
    check("model_mem0", m_mem[0], 16'd15);
    do_entry(16'd20, 16'd6, 2'b10);
    do_entry(16'd30, 16'd7, 2'b11);
    psum_buffer_ren = 1'b1; tick(); psum_buffer_ren = 1'b0; tick();
    check("ren_in_done_no_err", error, 1'b0);
    check("done_held", stall, 2'b11);

    pulse_grst();
    check("grst_stall", stall, 2'b00);
    check("grst_can_read", can_read_psum, 1'b1);
    do_entry(16'd0, 16'd15, 2'b10);

    done = 1'b1; tick(); done = 1'b0;
    check("err_done_idle", error, 1'b1);
    tick();
    check("err_sticky", error, 1'b1);
    do_entry(16'd0, 16'd26, 2'b10);
    pulse_grst();
    check("grst_clears_err", error, 1'b0);

    result_in = 16'h7FF0; next_psum_waddr = 1'b1; tick(); next_psum_waddr = 1'b0;
    do_entry(16'h0020, 16'h7FF0, 2'b10);
    pulse_grst();
    psum_buffer_ren = 1'b1; tick(); psum_buffer_ren = 1'b0; tick();
    check("ovf_valid", psum_buffer_valid, 1'b1);
    check("ovf_rdata", psum_rdata, EXP_OVF);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", psum_buffer_valid, 1'b0);
    check("async_rst_stall", stall, 2'b00);
    tick();
    reset = 1'b0;

    num_psums = 5'd0;
    for (int i = 0; i < D; i++) begin
      result_in = W'(3 * i + 1); next_psum_waddr = 1'b1;
      check("w_co_full", psum_w_co, i == D - 1);
      tick();
    end
    next_psum_waddr = 1'b0;
    check("w_co_full_wrapped", psum_w_co, 1'b0);
    do_entry(16'd0, 16'd1, 2'b10);

    for (int c = 0; c < 1500; c++) begin
      if (c % 250 == 249) begin
        global_rst = 1'b1;
        num_psums = AW'($urandom_range(0, 17)) == 0 ? 5'd0 : 5'($urandom_range(0, 17));
        tick(); global_rst = 1'b0;
      end
      result_in       = W'($urandom);
      next_psum_waddr = (m_st == S_IDLE) ? ($urandom_range(0, 99) < 25) : ($urandom_range(0, 99) < 2);
      psum_buffer_ren = (m_st == S_IDLE || m_st == S_DONE) ? ($urandom_range(0, 99) < 30)
                                                           : ($urandom_range(0, 99) < 2);
      done            = (m_st == S_VAL) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
      next_psum_raddr = (m_st == S_REP) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
      global_rst      = ($urandom_range(0, 199) == 0);
      tick();
    end
    next_psum_waddr = 1'b0; psum_buffer_ren = 1'b0; done = 1'b0;
    next_psum_raddr = 1'b0; global_rst = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
